// File: rtl/sha_round_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sha_round_ctrl
// Function : job wrapper and 64-round sequencer for the SHA-256 compression
//            datapath; drives round index and round constant, captures digest.
// Revision : 1.0
// ============================================================================
module sha_round_ctrl (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_m,
  input  logic [255:0] in_h0,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic         busy,
  output logic [5:0]   sha_round,
  output logic [31:0]  sha_kt,
  output logic [511:0] sha_m,
  output logic [255:0] sha_h0,
  input  logic [255:0] sha_h1
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [6:0] C_LAST_CNT = 7'd64;

  localparam logic [31:0] C_K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t         r_state;
  state_t         w_state_nxt;
  logic [6:0]     r_cnt;
  logic [31:0]    r_kt;
  logic [511:0]   r_m;
  logic [255:0]   r_h0;
  logic [255:0]   r_digest;
  logic           w_accept;
  logic           w_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    out_valid   = 1'b0;
    sha_round   = 6'd0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy   = 1'b1;
        w_last = (r_cnt == C_LAST_CNT);
        // At the final count the index wraps to 0, matching cnt[5:0].
        sha_round = r_cnt[5:0];
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= 7'd0;
      r_kt     <= 32'd0;
      r_m      <= 512'd0;
      r_h0     <= 256'd0;
      r_digest <= 256'd0;
    end else begin
      if (w_accept) begin
        r_m   <= in_m;
        r_h0  <= in_h0;
        r_cnt <= 7'd0;
      end
      if (busy) begin
        // Kt trails the index by one cycle to line up with the datapath's Wt register.
        r_kt <= C_K[sha_round];
        if (w_last) begin
          r_digest <= sha_h1;
          r_cnt    <= 7'd0;
        end else begin
          r_cnt <= r_cnt + 7'd1;
        end
      end
    end
  end

  assign sha_kt     = r_kt;
  assign sha_m      = r_m;
  assign sha_h0     = r_h0;
  assign out_digest = r_digest;

endmodule
`default_nettype wire

// File: tb/tb_sha_round_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for sha_round_ctrl: a behavioural SHA-256 round datapath closes the
// loop so real digests come back; directed jobs check handshakes and timing.
module tb_sha_round_ctrl;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_m;
  logic [255:0] in_h0;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_digest;
  logic         busy;
  logic [5:0]   sha_round;
  logic [31:0]  sha_kt;
  logic [511:0] sha_m;
  logic [255:0] sha_h0;
  logic [255:0] sha_h1;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [255:0] IV  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] M_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] M_EMPTY = {32'h80000000, 480'h0};
  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  sha_round_ctrl u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_m       (in_m),
    .in_h0      (in_h0),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_digest (out_digest),
    .busy       (busy),
    .sha_round  (sha_round),
    .sha_kt     (sha_kt),
    .sha_m      (sha_m),
    .sha_h0     (sha_h0),
    .sha_h1     (sha_h1)
  );

  always #5 clk = ~clk;

  // ---------------- SHA-256 datapath model ----------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sched(input logic [511:0] m, input int r);
    logic [31:0] w [64];
    for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7] +
             (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    return w[r];
  endfunction

  function automatic logic [255:0] rnd(input logic [255:0] s, input logic [31:0] k,
                                       input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

  logic [255:0] dp_state = '0;
  logic [31:0]  dp_wt    = '0;

  // State and Wt register on the edge that samples sha_round; Kt arrives a cycle later.
  always @(posedge clk) begin
    if (busy) begin
      dp_wt    <= sched(sha_m, int'(sha_round));
      dp_state <= (sha_round == 6'd0) ? sha_h0 : rnd(dp_state, sha_kt, dp_wt);
    end
  end

  assign sha_h1 = add8(sha_h0, rnd(dp_state, sha_kt, dp_wt));

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer a job from IDLE; returns at the negedge of cycle 0.
  task automatic start_job(input logic [511:0] m, input logic [255:0] h);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_m     = m;
    in_h0    = h;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // From the negedge of cycle 0, follow the job until out_valid rises.
  task automatic track_job(input logic [511:0] m, input logic [255:0] h,
                           input logic [255:0] exp, input bit scramble);
    int cyc;
    cyc = 0;
    chk("busy_c0", busy, 1);
    chk("in_ready_run", in_ready, 0);
    chk("sha_m_latch", sha_m, m);
    chk("sha_h0_latch", sha_h0, h);
    if (scramble) begin
      in_m  = ~m;
      in_h0 = ~h;
      in_valid = 1'b1;
    end
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1)  chk("kt_round0", sha_kt, 32'h428a2f98);
      if (cyc == 40) chk("sha_m_hold", sha_m, m);
      if (cyc == 63) chk("round_63", sha_round, 63);
      if (cyc == 64) begin
        chk("kt_round63", sha_kt, 32'hc67178f2);
        chk("round_wrap", sha_round, 0);
      end
    end
    in_valid = 1'b0;
    chk("latency", cyc, 65);
    chk("digest", out_digest, exp);
    chk("busy_done", busy, 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_m      = '0;
    in_h0     = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_round", sha_round, 0);
    chk("rst_kt", sha_kt, 0);
    chk("rst_digest", out_digest, 0);
    chk("rst_sha_m", sha_m, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // "abc" with port inputs disturbed during RUN
    start_job(M_ABC, IV);
    track_job(M_ABC, IV, D_ABC, 1'b1);
    @(negedge clk);
    chk("idle_out_valid", out_valid, 0);

    // empty message
    start_job(M_EMPTY, IV);
    track_job(M_EMPTY, IV, D_EMPTY, 1'b0);
    @(negedge clk);

    // output backpressure with a second job waiting
    out_ready = 1'b0;
    start_job(M_ABC, IV);
    track_job(M_ABC, IV, D_ABC, 1'b0);
    in_valid = 1'b1;
    in_m     = M_EMPTY;
    in_h0    = IV;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_digest", out_digest, D_ABC);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_idle_valid", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    track_job(M_EMPTY, IV, D_EMPTY, 1'b0);
    @(negedge clk);

    // reset mid-job
    start_job(M_ABC, IV);
    repeat (30) @(negedge clk);
    chk("pre_rst_round", sha_round, 30);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_round", sha_round, 0);
    chk("mid_rst_kt", sha_kt, 0);
    @(negedge clk);
    reset_n = 1'b1;
    start_job(M_ABC, IV);
    track_job(M_ABC, IV, D_ABC, 1'b0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha_round_ctrl.md
Name: sha_round_ctrl

Overview:
Sequencer and job wrapper for the 64-round SHA-256 compression datapath (sha_unit).
- Accepts one 512-bit message block plus 256-bit chaining value through a valid/ready handshake and holds both stable for the whole job.
- Drives the round index and the matching round constant Kt, then captures the final H1 as the digest.
- Presents the digest through a valid/ready output handshake.
- One job is in flight at a time.

Parameters:
None. Round count is fixed at 64 and the K table is the FIPS 180-4 constant set.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  job offered
- in_ready  out  1  block can accept a job
- in_m  in  512  message block; word 0 in [511:480], word 15 in [31:0]
- in_h0  in  256  chaining value; a in [255:224], h in [31:0]
- out_valid  out  1  digest available
- out_ready  in  1  consumer accepts digest
- out_digest  out  256  H1 captured at end of job, same word order as in_h0
- busy  out  1  high in RUN
- sha_round  out  6  round index to datapath
- sha_kt  out  32  round constant to datapath
- sha_m  out  512  latched message to datapath
- sha_h0  out  256  latched chaining value to datapath
- sha_h1  in  256  datapath result, combinational from its state register

Behaviour:
Reset (asynchronous on reset_n low):
- State is IDLE.
- cnt (7-bit) = 0; sha_round = 0; sha_kt = 0.
- sha_m, sha_h0, out_digest = 0.
- out_valid = 0, busy = 0, in_ready = 1 once reset_n is high.
- Reset mid-job discards the job; no digest is produced.

States: IDLE, RUN, DONE.

IDLE:
- in_ready = 1; sha_round = 0.
- Accept when in_valid && in_ready at a rising edge:
  - latch in_m to sha_m and in_h0 to sha_h0;
  - cnt <= 0; go to RUN.

RUN:
- in_ready = 0; busy = 1.
- sha_round = cnt[5:0] while cnt <= 63.
- Every edge: cnt <= cnt + 1.
- sha_kt is registered: sha_kt <= K[sha_round] at each edge in RUN. The datapath registers its state and Wt on the same edge that samples sha_round, so Kt must lag the round index by one cycle.
- When cnt == 64, sha_h1 holds the result after 64 rounds plus H0. At that edge:
  - out_digest <= sha_h1;
  - out_valid <= 1;
  - go to DONE;
  - sha_round returns to 0.

DONE:
- out_valid = 1; out_digest held stable.
- On out_valid && out_ready at an edge: out_valid <= 0; go to IDLE.
- in_ready stays 0 until IDLE is reached (no same-cycle turnaround).

Invariants:
- sha_m and sha_h0 stay stable from accept until the DONE→IDLE transition.
- Latency: accept edge = cycle 0; out_valid first high in cycle 65.
- Minimum job spacing is 67 cycles with out_ready held high.
- in_valid while not in IDLE is ignored. The input handshake follows standard valid/ready rules: the upstream holds its data until accepted.
- cnt never exceeds 64.
- The K table is a 64×32 constant ROM, indexed by sha_round.

Test Plan:
1. Message "abc": in_m = 0x61626380, 13×0x00000000, 0x00000000, 0x00000018; in_h0 = standard IV (6a09e667 … 5be0cd19) → out_valid in cycle 65 with out_digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
2. Empty message: in_m = 0x80000000 followed by zeros; IV → out_digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
3. Constant alignment → sha_kt = 0x428a2f98 in the cycle after sha_round = 0 is sampled, and sha_kt = 0xc67178f2 in the cycle after sha_round = 63 is sampled.
4. Output backpressure: hold out_ready = 0 for 10 cycles after out_valid rises while driving in_valid = 1 with a second job → out_digest stable, in_ready = 0 throughout. Then raise out_ready → IDLE, and the second job is accepted on the next edge.
5. Input hold: change in_m/in_h0 at the port during RUN → digest is unaffected (matches scenario 1).
6. Reset mid-job: assert reset_n = 0 at cnt = 30 → immediately out_valid = 0, busy = 0, sha_round = 0, sha_kt = 0. After release, a new "abc" job yields the scenario 1 digest.
